request_arbiter_4: RTL and testbench

REQUEST_ARBITER_4 -- requirements
Module: request_arbiter_4

---
 rtl/request_arbiter_4_pkg.sv | 22 ++
 rtl/request_arbiter_4_if.sv | 24 ++
 rtl/request_arbiter_4_rr_pick4.sv | 26 ++
 rtl/request_arbiter_4.sv | 89 ++++++++
 tb/tb_request_arbiter_4.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/request_arbiter_4_pkg.sv
// Shared definitions for the 4-requester round-robin grant arbiter.
package request_arbiter_4_pkg;

  localparam int unsigned NUM_REQ         = 4;
  localparam int unsigned TIMEOUT_DEFAULT = 15;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Index of the set bit in a one-hot grant vector (0 when empty).
  function automatic logic [1:0] onehot_idx(input logic [NUM_REQ-1:0] oh);
    logic [1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/request_arbiter_4_if.sv
// Request/grant bundle between requesters, arbiter and the downstream 4x2 encoder.
interface request_arbiter_4_if;
  import request_arbiter_4_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic               ack;
  logic               d0;
  logic               d1;
  logic               d2;
  logic               d3;
  logic               valid;
  logic               timeout;

  modport master (
    output req, ack,
    input  d0, d1, d2, d3, valid, timeout
  );

  modport slave (
    input  req, ack,
    output d0, d1, d2, d3, valid, timeout
  );

endinterface

// File: rtl/request_arbiter_4_rr_pick4.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping 3->0.
module rr_pick4
  import request_arbiter_4_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         ptr,
  output logic [NUM_REQ-1:0] pick,
  output logic               any
);

  logic [1:0] idx;

  always_comb begin
    pick = '0;
    any  = 1'b0;
    idx  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = ptr + 2'(k);
      if (req[idx] && !any) begin
        pick[idx] = 1'b1;
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/request_arbiter_4.sv
// Round-robin arbiter holding one registered one-hot grant until ack or hold timeout.
module request_arbiter_4
  import request_arbiter_4_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT,
  parameter int unsigned CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  request_arbiter_4_if.slave bus
);

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         ptr_q, ptr_d;
  logic               timeout_q, timeout_d;

  logic [NUM_REQ-1:0] pick;
  logic               any;
  logic               expired;

  rr_pick4 u_pick (
    .req  (bus.req),
    .ptr  (ptr_q),
    .pick (pick),
    .any  (any)
  );

  assign expired = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      cnt_q     <= '0;
      ptr_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (any) state_d = GRANT;
      GRANT: if (bus.ack || expired) state_d = IDLE;
    endcase
  end

  // Release by ack takes priority over timeout in the same cycle.
  always_comb begin
    grant_d   = grant_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    timeout_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        grant_d = any ? pick : '0;
        cnt_d   = '0;
      end
      GRANT: begin
        if (bus.ack) begin
          grant_d = '0;
          ptr_d   = onehot_idx(grant_q) + 2'd1;
        end else if (expired) begin
          grant_d   = '0;
          ptr_d     = onehot_idx(grant_q) + 2'd1;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  assign bus.d0      = grant_q[0];
  assign bus.d1      = grant_q[1];
  assign bus.d2      = grant_q[2];
  assign bus.d3      = grant_q[3];
  assign bus.valid   = |grant_q;
  assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_request_arbiter_4.sv
// Directed bench for request_arbiter_4 with a cycle-level reference model.
module tb_request_arbiter_4;

  localparam int TMO = 15;

  logic clk;
  logic rst;

  request_arbiter_4_if bus();

  request_arbiter_4 #(.TIMEOUT(TMO), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: granted index (-1 = none), cycles held so far, pointer, timeout pulse.
  int m_gnt;
  int m_held;
  int m_ptr;
  bit m_to;

  function automatic int first_from(input logic [3:0] r, input int p);
    for (int off = 0; off < 4; off++) begin
      if (r[(p + off) % 4]) return (p + off) % 4;
    end
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_gnt  <= -1;
      m_held <= 0;
      m_ptr  <= 0;
      m_to   <= 1'b0;
    end else begin
      m_to <= 1'b0;
      if (m_gnt < 0) begin
        m_gnt  <= first_from(bus.req, m_ptr);
        m_held <= 1;
      end else if (bus.ack) begin
        m_gnt <= -1;
        m_ptr <= (m_gnt + 1) % 4;
      end else if (m_held == TMO) begin
        m_gnt <= -1;
        m_ptr <= (m_gnt + 1) % 4;
        m_to  <= 1'b1;
      end else begin
        m_held <= m_held + 1;
      end
    end
  end

  function automatic logic [3:0] dvec();
    return {bus.d3, bus.d2, bus.d1, bus.d0};
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      check("model_grant", dvec(), (m_gnt < 0) ? 4'b0000 : 4'(1 << m_gnt));
      check("model_valid", bus.valid, (m_gnt >= 0));
      check("model_timeout", bus.timeout, m_to);
      check("onehot", $countones(dvec()) <= 1, 1);
    end
  end

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.valid === 1'b1) return;
    end
    check({name, "_wait_valid"}, 0, 1);
  endtask

  task automatic release_grant();
    drive_edge();
    bus.req = 4'b0000;
    bus.ack = 1'b1;
    drive_edge();
    bus.ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    logic [3:0] exp_seq [5];
    exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0010; exp_seq[2] = 4'b0100;
    exp_seq[3] = 4'b1000; exp_seq[4] = 4'b0001;

    rst = 1'b1;
    bus.req = 4'b0000;
    bus.ack = 1'b0;
    #12;
    check("reset_d", dvec(), 4'b0000);
    check("reset_valid", bus.valid, 1'b0);
    check("reset_timeout", bus.timeout, 1'b0);
    drive_edge();
    rst = 1'b0;

    // Round robin over all four requesters with ack after each grant.
    drive_edge();
    bus.req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      wait_valid("rr");
      check("rr_grant", dvec(), exp_seq[g]);
      drive_edge();
      bus.ack = 1'b1;
      drive_edge();
      bus.ack = 1'b0;
      if (g == 4) bus.req = 4'b0000;
      @(negedge clk);
      check("rr_gap_valid", bus.valid, 1'b0);
    end

    // Single requester with no ack: hold limit, timeout pulse, re-grant.
    drive_edge();
    bus.req = 4'b0100;
    wait_valid("tmo");
    cnt = 1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.d2 !== 1'b1) break;
      cnt++;
    end
    check("tmo_hold_cycles", cnt, TMO);
    check("tmo_pulse", bus.timeout, 1'b1);
    check("tmo_gap_d", dvec(), 4'b0000);
    @(negedge clk);
    check("tmo_regrant", dvec(), 4'b0100);
    check("tmo_pulse_end", bus.timeout, 1'b0);
    release_grant();

    // Grant stays put while its request drops; ptr then moves past it.
    drive_edge();
    bus.req = 4'b0010;
    wait_valid("hold");
    check("hold_grant", dvec(), 4'b0010);
    drive_edge();
    bus.req = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_stable", dvec(), 4'b0010);
    end
    drive_edge();
    bus.ack = 1'b1;
    drive_edge();
    bus.ack = 1'b0;
    bus.req = 4'b0110;
    @(negedge clk);
    check("hold_cleared", bus.valid, 1'b0);
    wait_valid("hold_next");
    check("hold_next_grant", dvec(), 4'b0100);
    release_grant();

    // ack coincides with the final hold cycle: release without timeout.
    drive_edge();
    bus.req = 4'b0001;
    wait_valid("race");
    check("race_grant", dvec(), 4'b0001);
    repeat (TMO - 1) @(posedge clk);
    #1;
    bus.ack = 1'b1;
    drive_edge();
    bus.ack = 1'b0;
    bus.req = 4'b0000;
    @(negedge clk);
    check("race_valid", bus.valid, 1'b0);
    check("race_timeout", bus.timeout, 1'b0);

    // ack while idle is ignored.
    drive_edge();
    bus.ack = 1'b1;
    drive_edge();
    bus.ack = 1'b0;
    @(negedge clk);
    check("idle_ack_d", dvec(), 4'b0000);
    check("idle_ack_timeout", bus.timeout, 1'b0);
    drive_edge();
    bus.req = 4'b0010;
    @(negedge clk);
    check("idle_ack_lat0", bus.valid, 1'b0);
    @(negedge clk);
    check("idle_ack_grant", dvec(), 4'b0010);
    release_grant();

    // Asynchronous reset mid-grant, then restart from requester 0.
    drive_edge();
    bus.req = 4'b1000;
    wait_valid("arst");
    check("arst_grant", dvec(), 4'b1000);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_d", dvec(), 4'b0000);
    check("arst_valid", bus.valid, 1'b0);
    check("arst_timeout", bus.timeout, 1'b0);
    bus.req = 4'b1001;
    drive_edge();
    rst = 1'b0;
    @(negedge clk);
    check("arst_post_idle", bus.valid, 1'b0);
    @(negedge clk);
    check("arst_post_grant", dvec(), 4'b0001);
    release_grant();
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
